// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the RV32I-subset datapath: per-state enables,
// a data-memory handshake with timeout, a debug halt, and a retired-instruction counter.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic [1:0]       alu_op,
  output logic             illegal_instr,
  output logic             bus_error,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] C_R       = 3'd0;
  localparam logic [2:0] C_I       = 3'd1;
  localparam logic [2:0] C_LOAD    = 3'd2;
  localparam logic [2:0] C_STORE   = 3'd3;
  localparam logic [2:0] C_BRANCH  = 3'd4;
  localparam logic [2:0] C_ILLEGAL = 3'd5;

  localparam int              WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  function automatic logic [2:0] decode_class(input logic [6:0] op);
    case (op)
      7'b0110011: decode_class = C_R;
      7'b0010011: decode_class = C_I;
      7'b0000011: decode_class = C_LOAD;
      7'b0100011: decode_class = C_STORE;
      7'b1100011: decode_class = C_BRANCH;
      default:    decode_class = C_ILLEGAL;
    endcase
  endfunction

  logic [2:0]        r_state;
  logic [2:0]        r_class;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_count;

  logic [2:0] w_dec_class;
  logic [2:0] w_next_state;
  logic       w_retire;
  logic       w_pc_write;
  logic       w_pc_src;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_alu_src;
  logic       w_mem_to_reg;
  logic [1:0] w_alu_op;
  logic       w_illegal;
  logic       w_bus_error;
  logic       w_halted;

  // opcode is only trusted from DECODE on, so DECODE looks at it directly
  assign w_dec_class = decode_class(opcode);

  always_comb begin
    w_next_state = S_FETCH;
    w_retire     = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_op     = 2'b00;
    w_illegal    = 1'b0;
    w_bus_error  = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (halt_req) begin
          w_next_state = S_HALT;
        end else begin
          w_ir_write   = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_dec_class == C_ILLEGAL) begin
          w_illegal    = 1'b1;
          w_pc_write   = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        case (r_class)
          C_R: begin
            w_alu_op     = 2'b10;
            w_next_state = S_WB;
          end
          C_I: begin
            w_alu_op     = 2'b11;
            w_alu_src    = 1'b1;
            w_next_state = S_WB;
          end
          C_LOAD, C_STORE: begin
            w_alu_op     = 2'b00;
            w_alu_src    = 1'b1;
            w_next_state = S_MEM;
          end
          C_BRANCH: begin
            w_alu_op     = 2'b01;
            w_pc_write   = 1'b1;
            w_pc_src     = zero;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end
          default: w_next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_alu_src   = 1'b1;
        w_mem_read  = (r_class == C_LOAD);
        w_mem_write = (r_class == C_STORE);
        // a completion in the final allowed cycle beats the timeout
        if (mem_ready) begin
          if (r_class == C_LOAD) begin
            w_next_state = S_WB;
          end else begin
            w_pc_write   = 1'b1;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_bus_error  = 1'b1;
          w_pc_write   = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_MEM;
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (r_class == C_LOAD);
        w_pc_write   = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT: begin
        w_halted     = 1'b1;
        w_next_state = halt_req ? S_HALT : S_FETCH;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_class    <= C_ILLEGAL;
      r_wait_cnt <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_class <= w_dec_class;
      end
      // staying in MEM implies mem_ready was low; any other path clears for the next entry
      if ((r_state == S_MEM) && (w_next_state == S_MEM)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_retire) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // every output reads as zero for as long as reset is held
  always_comb begin
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_op        = 2'b00;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;
    halted        = 1'b0;
    retired_count = '0;
    state_dbg     = 3'd0;
    if (!reset) begin
      pc_write      = w_pc_write;
      pc_src        = w_pc_src;
      ir_write      = w_ir_write;
      reg_write     = w_reg_write;
      mem_read      = w_mem_read;
      mem_write     = w_mem_write;
      alu_src       = w_alu_src;
      mem_to_reg    = w_mem_to_reg;
      alu_op        = w_alu_op;
      illegal_instr = w_illegal;
      bus_error     = w_bus_error;
      halted        = w_halted;
      retired_count = r_count;
      state_dbg     = r_state;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: per-instruction summaries
// predicted from the latency/strobe rules are compared against what the monitor observes.
module tb_multicycle_controller;

  localparam int T  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic          halt_req;
  logic          pc_write;
  logic          pc_src;
  logic          ir_write;
  logic          reg_write;
  logic          mem_read;
  logic          mem_write;
  logic          alu_src;
  logic          mem_to_reg;
  logic [1:0]    alu_op;
  logic          illegal_instr;
  logic          bus_error;
  logic          halted;
  logic [CW-1:0] retired_count;
  logic [2:0]    state_dbg;

  multicycle_controller #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .halt_req(halt_req), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .alu_op(alu_op), .illegal_instr(illegal_instr),
    .bus_error(bus_error), .halted(halted), .retired_count(retired_count),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // One record spans a FETCH cycle up to (not including) the next FETCH cycle
  typedef struct {
    int len; int ir; int mr; int mw; int rw; int ill; int be;
    int pcw; int pcs; int m2r; int hlt; int asrc; int aop2; int asrc2; int rc0;
  } rec_t;

  rec_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   mcnt   = 0;
  int   nrec   = 0;

  function automatic rec_t clr_rec();
    rec_t r;
    r.len = 0; r.ir = 0; r.mr = 0; r.mw = 0; r.rw = 0; r.ill = 0; r.be = 0;
    r.pcw = 0; r.pcs = 0; r.m2r = 0; r.hlt = 0; r.asrc = 0; r.aop2 = 0; r.asrc2 = 0; r.rc0 = 0;
    return r;
  endfunction

  function automatic logic [6:0] opc_of(input int cls);
    logic [6:0] ill_ops [5];
    ill_ops = '{7'h7f, 7'b0110111, 7'b1101111, 7'h00, 7'b0110010};
    case (cls)
      0: return 7'b0110011;
      1: return 7'b0010011;
      2: return 7'b0000011;
      3: return 7'b0100011;
      4: return 7'b1100011;
      6: return 7'h7f;
      default: return ill_ops[$urandom_range(0, 4)];
    endcase
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic close_rec(input rec_t a);
    rec_t  e;
    string p;
    nrec++;
    p = $sformatf("rec%0d", nrec);
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected actual=extra_record required=none", p);
    end else begin
      e = expq.pop_front();
      cmp({p, ".len"}, a.len, e.len);
      cmp({p, ".ir_write"}, a.ir, e.ir);
      cmp({p, ".mem_read"}, a.mr, e.mr);
      cmp({p, ".mem_write"}, a.mw, e.mw);
      cmp({p, ".reg_write"}, a.rw, e.rw);
      cmp({p, ".illegal"}, a.ill, e.ill);
      cmp({p, ".bus_error"}, a.be, e.be);
      cmp({p, ".pc_write"}, a.pcw, e.pcw);
      cmp({p, ".pc_src"}, a.pcs, e.pcs);
      cmp({p, ".mem_to_reg"}, a.m2r, e.m2r);
      cmp({p, ".halted"}, a.hlt, e.hlt);
      cmp({p, ".alu_src_cycles"}, a.asrc, e.asrc);
      cmp({p, ".exec_alu_op"}, a.aop2, e.aop2);
      cmp({p, ".exec_alu_src"}, a.asrc2, e.asrc2);
      cmp({p, ".retired_count"}, a.rc0, e.rc0);
    end
  endtask

  // Monitor: samples on the falling edge, builds records, checks per-cycle rules
  rec_t cur;
  bit   open_r = 1'b0;

  always @(negedge clk) begin
    int ns;
    if (reset) begin
      checks++;
      if ({pc_write, pc_src, ir_write, reg_write, mem_read, mem_write, alu_src, mem_to_reg,
           alu_op, illegal_instr, bus_error, halted, retired_count, state_dbg} != '0) begin
        errors++;
        $display("FAIL reset_outputs actual=%h required=0",
                 {pc_write, pc_src, ir_write, reg_write, mem_read, mem_write, alu_src, mem_to_reg,
                  alu_op, illegal_instr, bus_error, halted, retired_count, state_dbg});
      end
      open_r = 1'b0;
    end else begin
      if (!open_r) cmp("first_state_after_reset", int'(state_dbg), 0);
      if (state_dbg == 3'd0) begin
        if (open_r) close_rec(cur);
        cur     = clr_rec();
        cur.rc0 = int'(retired_count);
        open_r  = 1'b1;
      end
      if (open_r) begin
        if (cur.len == 2) begin
          cur.aop2  = int'(alu_op);
          cur.asrc2 = int'(alu_src);
        end
        cur.len++;
        cur.ir   += int'(ir_write);
        cur.mr   += int'(mem_read);
        cur.mw   += int'(mem_write);
        cur.rw   += int'(reg_write);
        cur.ill  += int'(illegal_instr);
        cur.be   += int'(bus_error);
        cur.pcw  += int'(pc_write);
        cur.pcs  += int'(pc_src);
        cur.m2r  += int'(mem_to_reg);
        cur.hlt  += int'(halted);
        cur.asrc += int'(alu_src);
      end
      ns = int'(ir_write) + int'(reg_write) + int'(mem_read) + int'(mem_write);
      checks++;
      if (ns > 1) begin
        errors++;
        $display("FAIL strobe_onehot actual=%0d required<=1", ns);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cls: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5/6 ILLEGAL; w = MEM wait cycles (>=T: timeout);
  // hk>0 raises halt_req from that cycle of the instruction onward
  task automatic do_instr(input int cls, input int w, input bit zv, input int hk);
    rec_t       e;
    int         len;
    int         ret;
    logic [6:0] op;
    e     = clr_rec();
    e.ir  = 1;
    e.rc0 = mcnt;
    ret   = 0;
    op    = opc_of(cls);
    case (cls)
      0: begin len = 4; e.rw = 1; e.pcw = 1; e.aop2 = 2; ret = 1; end
      1: begin len = 4; e.rw = 1; e.pcw = 1; e.aop2 = 3; e.asrc2 = 1; e.asrc = 1; ret = 1; end
      2, 3: begin
        e.asrc2 = 1;
        e.pcw   = 1;
        if (w < T) begin
          len    = (cls == 2) ? 5 + w : 4 + w;
          e.asrc = 2 + w;
          ret    = 1;
          if (cls == 2) begin e.mr = 1 + w; e.rw = 1; e.m2r = 1; end
          else e.mw = 1 + w;
        end else begin
          len    = 3 + T;
          e.asrc = 1 + T;
          e.be   = 1;
          if (cls == 2) e.mr = T; else e.mw = T;
        end
      end
      4: begin len = 3; e.pcw = 1; e.pcs = int'(zv); e.aop2 = 1; ret = 1; end
      default: begin len = 2; e.pcw = 1; e.ill = 1; end
    endcase
    e.len = len;
    expq.push_back(e);
    mcnt = (mcnt + ret) % (1 << CW);
    for (int k = 0; k < len; k++) begin
      opcode    = (k == 0) ? 7'($urandom) : op;
      zero      = (k == 2) ? zv : 1'($urandom);
      mem_ready = ((cls == 2 || cls == 3) && k >= 3) ? ((k - 3) == w) : 1'($urandom);
      halt_req  = (k == 0) ? 1'b0 : ((hk > 0 && k >= hk) ? 1'b1 : 1'($urandom));
      tick();
    end
  endtask

  task automatic do_halt(input int n);
    rec_t e;
    e     = clr_rec();
    e.len = n + 1;
    e.hlt = n;
    e.rc0 = mcnt;
    expq.push_back(e);
    for (int k = 0; k <= n; k++) begin
      opcode    = 7'($urandom);
      zero      = 1'($urandom);
      mem_ready = 1'($urandom);
      halt_req  = (k < n);
      tick();
    end
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      reset     = 1'b1;
      opcode    = 7'($urandom);
      zero      = 1'($urandom);
      mem_ready = 1'($urandom);
      halt_req  = 1'($urandom);
      tick();
    end
    reset = 1'b0;
    mcnt  = 0;
  endtask

  task automatic abort_mem();
    for (int k = 0; k < 5; k++) begin
      opcode    = (k == 0) ? 7'($urandom) : 7'b0000011;
      zero      = 1'($urandom);
      mem_ready = (k >= 3) ? 1'b0 : 1'($urandom);
      halt_req  = (k == 0) ? 1'b0 : 1'($urandom);
      tick();
    end
    do_reset(2);
  endtask

  task automatic abort_halt();
    for (int k = 0; k < 3; k++) begin
      opcode    = 7'($urandom);
      zero      = 1'($urandom);
      mem_ready = 1'($urandom);
      halt_req  = 1'b1;
      tick();
    end
    do_reset(2);
  endtask

  initial begin
    int cls;
    int hk;
    reset     = 1'b1;
    opcode    = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    halt_req  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    do_instr(0, 0, 1'b0, 0);
    do_instr(2, 2, 1'b0, 0);
    do_instr(4, 0, 1'b1, 0);
    do_instr(4, 0, 1'b0, 0);
    do_instr(3, T, 1'b0, 0);
    do_instr(3, T - 1, 1'b0, 0);
    do_instr(2, T, 1'b1, 0);
    do_instr(2, T - 1, 1'b0, 0);
    do_instr(6, 0, 1'b0, 0);
    do_instr(1, 0, 1'b1, 0);
    do_instr(0, 0, 1'b0, 2);
    do_halt(3);
    do_instr(3, 0, 1'b0, 0);
    do_instr(2, 0, 1'b0, 0);
    abort_mem();
    repeat (16) do_instr(0, 0, 1'b0, 0);
    do_instr(5, 0, 1'b0, 0);
    do_halt(1);
    abort_halt();

    for (int i = 0; i < 80; i++) begin
      cls = $urandom_range(0, 5);
      hk  = ($urandom_range(0, 5) == 0) ? 1 + $urandom_range(0, 1) : 0;
      do_instr(cls, $urandom_range(0, 5), 1'($urandom), hk);
      if (hk > 0) do_halt($urandom_range(1, 3));
    end

    do_instr(5, 0, 1'b0, 0);
    opcode   = 7'($urandom);
    halt_req = 1'b0;
    tick();
    do_reset(2);
    @(negedge clk);
    cmp("pending_expectations", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
